// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit (see multicycle_ctrl_fsm,
// optional CTRL_PERF_CNT_EN retire counter).
package ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_BEQ = 2'b11;

   localparam int unsigned CTRL_REGDST   = 7;
   localparam int unsigned CTRL_REGWRITE = 6;
   localparam int unsigned CTRL_ALUSRC   = 5;
   localparam int unsigned CTRL_BRANCH   = 4;
   localparam int unsigned CTRL_MEMREAD  = 3;
   localparam int unsigned CTRL_MEMWRITE = 2;
   localparam int unsigned CTRL_MEMTOREG = 1;
   localparam int unsigned CTRL_ALUOP    = 0;

   typedef struct packed {
      logic legal;
      logic reg_dst;
      logic alu_src;
      logic mem_to_reg;
      logic alu_op;
      logic is_ld;
      logic is_st;
      logic is_br;
   } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: legality, static datapath bits and instruction class.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 2
) (
   input  logic [OPCODE_W-1:0] opcode,
   output dec_t                dec
);

   logic [1:0] op;
   assign op = opcode[1:0];

   always_comb begin
      dec = '0;
      // any set bit above the two class bits makes the opcode illegal
      dec.legal = ((opcode >> 2) == '0);
      if (dec.legal) begin
         unique case (op)
            OP_ADD: begin
               dec.reg_dst = 1'b1;
               dec.alu_op  = 1'b1;
            end
            OP_LW: begin
               dec.alu_src    = 1'b1;
               dec.mem_to_reg = 1'b1;
               dec.is_ld      = 1'b1;
            end
            OP_SW: begin
               dec.alu_src = 1'b1;
               dec.is_st   = 1'b1;
            end
            OP_BEQ: begin
               dec.is_br = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM (IDLE/DECODE/EXEC/MEM/WB) with memory-wait timeout and illegal-opcode
// drop. Define CTRL_PERF_CNT_EN to add the retire_cnt counter and port.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 2,
   parameter int unsigned MEM_TIMEOUT = 15
`ifdef CTRL_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W       = 16
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                instr_ready,
   input  logic                mem_ack,
   output logic [7:0]          ctrl_sign,
   output logic                retire,
   output logic                illegal,
   output logic                mem_err,
   output logic [2:0]          state_o
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    retire_cnt
`endif
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

   state_t              state, state_d;
   logic [OPCODE_W-1:0] ir;
   logic [3:0]          stat, stat_d;   // {reg_dst, alu_src, mem_to_reg, alu_op}
   logic [TW-1:0]       timer, timer_d;
   logic [7:0]          ctrl_d;
   logic                timeout;
   dec_t                dec;

   ctrl_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .opcode (ir),
      .dec    (dec)
   );

   assign state_o = state;
   assign timeout = (timer == TW'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d = state;
      timer_d = timer;
      stat_d  = stat;
      retire  = 1'b0;
      illegal = 1'b0;
      mem_err = 1'b0;
      case (state)
         IDLE: begin
            if (instr_valid) state_d = DECODE;
         end
         DECODE: begin
            stat_d = {dec.reg_dst, dec.alu_src, dec.mem_to_reg, dec.alu_op};
            if (dec.legal) begin
               state_d = EXEC;
            end else begin
               illegal = 1'b1;
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (dec.is_br) begin
               retire  = 1'b1;
               state_d = IDLE;
            end else if (dec.is_ld || dec.is_st) begin
               timer_d = '0;
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            // an ack in the timeout cycle still completes the access
            if (mem_ack) begin
               if (dec.is_st) begin
                  retire  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WB;
               end
            end else if (timeout) begin
               mem_err = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         WB: begin
            retire  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control word for the state being entered, so ctrl_sign comes straight from a flop.
   always_comb begin
      ctrl_d                = '0;
      ctrl_d[CTRL_REGDST]   = stat_d[3];
      ctrl_d[CTRL_ALUSRC]   = stat_d[2];
      ctrl_d[CTRL_MEMTOREG] = stat_d[1];
      ctrl_d[CTRL_ALUOP]    = stat_d[0];
      ctrl_d[CTRL_REGWRITE] = (state_d == WB);
      ctrl_d[CTRL_BRANCH]   = (state_d == EXEC) && dec.is_br;
      ctrl_d[CTRL_MEMREAD]  = (state_d == MEM) && dec.is_ld;
      ctrl_d[CTRL_MEMWRITE] = (state_d == MEM) && dec.is_st;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ir          <= '0;
         stat        <= '0;
         timer       <= '0;
         ctrl_sign   <= '0;
         instr_ready <= 1'b1;
      end else begin
         state       <= state_d;
         stat        <= stat_d;
         timer       <= timer_d;
         ctrl_sign   <= ctrl_d;
         instr_ready <= (state_d == IDLE);
         if ((state == IDLE) && instr_valid) ir <= opcode;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_cnt <= '0;
      end else if (retire) begin
         retire_cnt <= retire_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected trace model plus literal
// spot checks; covers CTRL_PERF_CNT_EN when defined.
module tb_multicycle_ctrl_fsm;

   localparam int TMO = 15;
   localparam logic [7:0] QMASK = 8'h5C;   // RegWrite, Branch, MemRead, MemWrite

   typedef struct packed {
      logic       chk;
      logic       valid;
      logic [3:0] opc;
      logic       ack;
      logic [2:0] st;
      logic       rdy;
      logic [7:0] ctrl;
      logic [7:0] mask;
      logic       ret;
      logic       ill;
      logic       merr;
   } ent_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic [3:0] opcode;
   logic       instr_ready;
   logic       mem_ack;
   logic [7:0] ctrl_sign;
   logic       retire;
   logic       illegal;
   logic       mem_err;
   logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0] retire_cnt;
`endif

   int          n_chk  = 0;
   int          n_fail = 0;
   ent_t        q[$];
   ent_t        cur;
   logic [15:0] exp_cnt = '0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(
      .OPCODE_W    (4),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .opcode      (opcode),
      .instr_ready (instr_ready),
      .mem_ack     (mem_ack),
      .ctrl_sign   (ctrl_sign),
      .retire      (retire),
      .illegal     (illegal),
      .mem_err     (mem_err),
      .state_o     (state_o)
`ifdef CTRL_PERF_CNT_EN
      ,
      .retire_cnt  (retire_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic valid, input logic [3:0] opc, input logic ack,
                               input logic [2:0] st, input logic [7:0] ctrl,
                               input logic [7:0] mask, input logic ret, input logic ill,
                               input logic merr);
      ent_t e;
      e.chk = 1'b1; e.valid = valid; e.opc = opc; e.ack = ack; e.st = st;
      e.rdy = (st == 3'd0); e.ctrl = ctrl; e.mask = mask;
      e.ret = ret; e.ill = ill; e.merr = merr;
      return e;
   endfunction

   // Expected cycle trace of one instruction starting at its handshake cycle.
   // k: MEM cycle (1-based) in which mem_ack is given; 0 or >TMO means never.
   task automatic build(input logic [3:0] opc, input int k, input logic hold);
      logic [1:0] low;
      logic       legal;
      logic       acked;
      logic [7:0] stat;
      int         n;
      low   = opc[1:0];
      legal = (opc[3:2] == 2'b00);
      acked = (k >= 1) && (k <= TMO);
      case (low)
         2'd0:    stat = 8'h81;
         2'd1:    stat = 8'h22;
         2'd2:    stat = 8'h20;
         default: stat = 8'h00;
      endcase
      q.push_back(mk(1'b1, opc, 1'b0, 3'd0, 8'h00, QMASK, 1'b0, 1'b0, 1'b0));
      // garbage opcode and a stray mem_ack while decoding must be ignored
      q.push_back(mk(hold, ~opc, 1'b1, 3'd1, 8'h00, QMASK, 1'b0, !legal, 1'b0));
      if (legal) begin
         q.push_back(mk(hold, ~opc, 1'b0, 3'd2, stat | ((low == 2'd3) ? 8'h10 : 8'h00),
                        8'hFF, low == 2'd3, 1'b0, 1'b0));
         if (low == 2'd0) begin
            q.push_back(mk(hold, ~opc, 1'b0, 3'd4, stat | 8'h40, 8'hFF, 1'b1, 1'b0, 1'b0));
         end else if (low != 2'd3) begin
            n = acked ? k : TMO;
            for (int i = 1; i <= n; i++) begin
               q.push_back(mk(hold, ~opc, acked && (i == k), 3'd3,
                              stat | ((low == 2'd1) ? 8'h08 : 8'h04), 8'hFF,
                              acked && (i == k) && (low == 2'd2), 1'b0, !acked && (i == n)));
            end
            if (acked && low == 2'd1)
               q.push_back(mk(hold, ~opc, 1'b0, 3'd4, stat | 8'h40, 8'hFF, 1'b1, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (q.size() > 0) cur = q.pop_front();
         else cur = mk(1'b0, 4'h0, 1'b0, 3'd0, 8'h00, QMASK, 1'b0, 1'b0, 1'b0);
         instr_valid = cur.valid;
         opcode      = cur.opc;
         mem_ack     = cur.ack;
      end
   endtask

   task automatic drain();
      while (q.size() > 0) run(1);
      run(2);
   endtask

   // Per-cycle comparison against the expected trace.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) exp_cnt = '0;
         if (cur.chk && !reset) begin
            chk("state_o", state_o, cur.st);
            chk("instr_ready", instr_ready, cur.rdy);
            chk("ctrl_sign", ctrl_sign & cur.mask, cur.ctrl & cur.mask);
            chk("retire", retire, cur.ret);
            chk("illegal", illegal, cur.ill);
            chk("mem_err", mem_err, cur.merr);
`ifdef CTRL_PERF_CNT_EN
            chk("retire_cnt", retire_cnt, exp_cnt);
`endif
            if (cur.ret) exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   initial begin
      cur         = '0;
      reset       = 1'b1;
      instr_valid = 1'b0;
      opcode      = 4'h0;
      mem_ack     = 1'b0;
      #13;
      chk("rst_state", state_o, 3'd0);
      chk("rst_ready", instr_ready, 1'b1);
      chk("rst_ctrl", ctrl_sign, 8'h00);
      chk("rst_pulses", {retire, illegal, mem_err}, 3'b000);
      #4 reset = 1'b0;
      run(2);

      // ADD
      build(4'h0, 0, 1'b0);
      run(3); @(negedge clk); chk("add_exec_ctrl", ctrl_sign, 8'b10000001);
      run(1); @(negedge clk); chk("add_wb_ctrl", ctrl_sign, 8'b11000001);
      chk("add_wb_retire", retire, 1'b1);
      run(1); @(negedge clk); chk("add_ready_c4", instr_ready, 1'b1);
      drain();

      // LW, ack in third MEM cycle
      build(4'h1, 3, 1'b0);
      run(6); @(negedge clk); chk("lw_mem3_ctrl", ctrl_sign, 8'b00101010);
      run(1); @(negedge clk); chk("lw_wb_ctrl", ctrl_sign, 8'b01100010);
      chk("lw_wb_retire", retire, 1'b1);
      run(1); @(negedge clk); chk("lw_ready_c7", instr_ready, 1'b1);
      drain();

      // SW, no ack: timeout
      build(4'h2, 0, 1'b0);
      run(18); @(negedge clk); chk("sw_to_memerr", mem_err, 1'b1);
      chk("sw_to_ctrl", ctrl_sign, 8'b00100100);
      chk("sw_to_noretire", retire, 1'b0);
      run(1); @(negedge clk); chk("sw_to_idle", state_o, 3'd0);
      drain();

      // BEQ with instr_valid held, back-to-back ADD
      build(4'h3, 0, 1'b1);
      build(4'h0, 0, 1'b0);
      run(3); @(negedge clk); chk("beq_exec_ctrl", ctrl_sign, 8'b00010000);
      chk("beq_retire", retire, 1'b1);
      run(1); @(negedge clk); chk("beq_ready_c3", instr_ready, 1'b1);
      drain();

      // Illegal opcodes
      build(4'h5, 0, 1'b0);
      run(2); @(negedge clk); chk("ill_pulse", illegal, 1'b1);
      chk("ill_qual_bits", ctrl_sign & QMASK, 8'h00);
      run(1); @(negedge clk); chk("ill_idle", state_o, 3'd0);
      drain();
      build(4'h8, 0, 1'b0);
      drain();

      // Boundaries: first-cycle ack, ack in the timeout cycle, LW timeout
      build(4'h2, 1, 1'b0);
      build(4'h1, 1, 1'b0);
      build(4'h2, TMO, 1'b0);
      build(4'h1, TMO + 1, 1'b0);
      drain();

      // Reset in MEM of LW
      build(4'h1, 0, 1'b0);
      run(5);
      #2;
      cur.chk = 1'b0;
      q.delete();
      reset = 1'b1;
      #1;
      chk("midrst_ctrl", ctrl_sign, 8'h00);
      chk("midrst_state", state_o, 3'd0);
      chk("midrst_pulses", {retire, illegal, mem_err}, 3'b000);
      chk("midrst_ready", instr_ready, 1'b1);
      @(posedge clk);
      #2 reset = 1'b0;
      build(4'h0, 0, 1'b0);
      run(4); @(negedge clk); chk("post_rst_add_retire", retire, 1'b1);
      run(1);
`ifdef CTRL_PERF_CNT_EN
      @(negedge clk); chk("post_rst_retire_cnt", retire_cnt, 16'd1);
`endif
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
